// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner for a packed BCD decade-counter chain.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit0 never blanked).
module bcd_display_scanner #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 1000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  decade_rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  load,
    input  logic                  enable,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done,
    output logic                  bcd_err
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] AN_OFF   = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BCD_W-1:0]  shadow_q, shadow_d;
    logic [BCD_W-1:0]  pending_q, pending_d;
    logic              pend_v_q, pend_v_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              frame_done_q, frame_done_d;
    logic              bcd_err_q, bcd_err_d;

    logic              tick_c;
    logic              wrap_c;
    logic [3:0]        digit_c;
    logic              blank_c;
    logic [6:0]        seg_act_c;
    logic [DIGITS-1:0] an_act_c;

    function automatic logic [6:0] bcd_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Prescaler and digit index advance
    always_comb begin
        tick_c = enable && (cnt_q == CNT_LAST);
        wrap_c = tick_c && (idx_q == IDX_LAST);
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        if (enable) begin
            cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
        end
        if (tick_c) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Pending/shadow capture; shadow only changes at a frame wrap so a frame is coherent
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;
        if (load) begin
            pending_d = bcd_in;
            pend_v_d  = 1'b1;
        end
        if (wrap_c) begin
            if (load) begin
                shadow_d = bcd_in;
            end else if (pend_v_q) begin
                shadow_d = pending_q;
            end
            pend_v_d = 1'b0;
        end
    end

    // Digit selected for the slot being entered, using the post-wrap shadow
    always_comb begin
        digit_c = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                digit_c = shadow_d[4*i +: 4];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every digit above it are zero
    logic hi_zero_c;
    always_comb begin
        blank_c   = 1'b0;
        hi_zero_c = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            hi_zero_c = hi_zero_c && (shadow_d[4*i +: 4] == 4'd0);
            if (hi_zero_c && (idx_d == IDX_W'(i))) begin
                blank_c = 1'b1;
            end
        end
    end
`else
    assign blank_c = 1'b0;
`endif

    // Output next-state: anode dark during the ghost-guard cycle after each tick
    always_comb begin
        seg_act_c    = blank_c ? 7'h00 : bcd_decode(digit_c);
        an_act_c     = (enable && !tick_c) ? (DIGITS'(1) << idx_q) : '0;
        seg_d        = ACTIVE_LOW ? ~seg_act_c : seg_act_c;
        an_d         = ACTIVE_LOW ? ~an_act_c : an_act_c;
        frame_done_d = wrap_c;
        bcd_err_d    = bcd_err_q || (!blank_c && (digit_c > 4'd9));
    end

    always_ff @(posedge clk or posedge decade_rst) begin
        if (decade_rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            pending_q    <= '0;
            pend_v_q     <= 1'b0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
            bcd_err_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_v_q     <= pend_v_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
            bcd_err_q    <= bcd_err_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign bcd_err    = bcd_err_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner (DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0): vector table,
// directed corner sequences and randomized traffic against a frame/slot arithmetic model.
module tb_bcd_display_scanner;

    logic        clk;
    logic        decade_rst;
    logic [15:0] bcd_in;
    logic        load;
    logic        enable;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;
    logic        bcd_err;

    bcd_display_scanner #(
        .DIGITS      (4),
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (1'b0)
    ) dut (
        .clk        (clk),
        .decade_rst (decade_rst),
        .bcd_in     (bcd_in),
        .load       (load),
        .enable     (enable),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .bcd_err    (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: time is counted in enabled clocks; slot = count/4, digit = slot%4
    logic [6:0]  seg_tab [16];
    int          m_ecnt;
    logic [15:0] m_shadow, m_pending;
    logic        m_pendv, m_err, m_fd;
    logic [6:0]  m_seg;
    logic [3:0]  m_an;

    task automatic model_reset();
        m_ecnt = 0; m_shadow = '0; m_pending = '0; m_pendv = 0;
        m_err = 0; m_fd = 0; m_seg = '0; m_an = '0;
    endtask

    task automatic model_step(input logic en, input logic ld, input logic [15:0] bcd);
        int  pre, slot, idx, dig;
        bit  tick, wrap, blank;
        pre  = m_ecnt % 4;
        slot = m_ecnt / 4;
        tick = en && (pre == 3);
        wrap = tick && (slot % 4 == 3);
        if (en) m_ecnt++;
        idx = (m_ecnt / 4) % 4;
        if (wrap) begin
            if (ld) m_shadow = bcd;
            else if (m_pendv) m_shadow = m_pending;
            m_pendv = 0;
        end else if (ld) begin
            m_pending = bcd;
            m_pendv   = 1;
        end
        dig   = int'((m_shadow >> (4 * idx)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx > 0) && ((m_shadow >> (4 * idx)) == 16'h0);
`else
        blank = 0;
`endif
        m_seg = blank ? 7'h00 : seg_tab[dig];
        if (!blank && dig > 9) m_err = 1;
        m_an  = (en && !tick) ? 4'(1 << idx) : 4'b0000;
        m_fd  = wrap;
    endtask

    task automatic step(input logic en, input logic ld, input logic [15:0] bcd);
        enable = en; load = ld; bcd_in = bcd;
        @(posedge clk);
        #1;
        model_step(en, ld, bcd);
        chk("seg", 32'(seg), 32'(m_seg));
        chk("an", 32'(an), 32'(m_an));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("bcd_err", 32'(bcd_err), 32'(m_err));
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic async_reset();
        #2;
        decade_rst = 1'b1;
        load = 1'b0;
        #1;
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_an", 32'(an), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        chk("rst_err", 32'(bcd_err), 32'h0);
        model_reset();
        @(negedge clk);
        decade_rst = 1'b0;
    endtask

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] bcd;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        fd;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic ld, input logic [15:0] bcd, input logic [3:0] a,
                                input logic [6:0] s, input logic f);
        vec_t v;
        v.en = 1'b1; v.ld = ld; v.bcd = bcd; v.an = a; v.seg = s; v.fd = f;
        return v;
    endfunction

    logic [6:0] t3_exp [4];
    logic [15:0] rb;

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        t3_exp  = '{7'h7F, 7'h07, 7'h7D, 7'h6D};

        // First frame from reset, a mid-frame load of 1234 applied at the wrap
        tbl[0]  = mk(0, 16'h0, 4'b0001, 7'h3F, 0);
        tbl[1]  = mk(0, 16'h0, 4'b0001, 7'h3F, 0);
        tbl[2]  = mk(0, 16'h0, 4'b0001, 7'h3F, 0);
        tbl[3]  = mk(0, 16'h0, 4'b0000, 7'h3F, 0);
        tbl[4]  = mk(0, 16'h0, 4'b0010, 7'h3F, 0);
        tbl[5]  = mk(1, 16'h1234, 4'b0010, 7'h3F, 0);
        tbl[6]  = mk(0, 16'h0, 4'b0010, 7'h3F, 0);
        tbl[7]  = mk(0, 16'h0, 4'b0000, 7'h3F, 0);
        tbl[8]  = mk(0, 16'h0, 4'b0100, 7'h3F, 0);
        tbl[9]  = mk(0, 16'h0, 4'b0100, 7'h3F, 0);
        tbl[10] = mk(0, 16'h0, 4'b0100, 7'h3F, 0);
        tbl[11] = mk(0, 16'h0, 4'b0000, 7'h3F, 0);
        tbl[12] = mk(0, 16'h0, 4'b1000, 7'h3F, 0);
        tbl[13] = mk(0, 16'h0, 4'b1000, 7'h3F, 0);
        tbl[14] = mk(0, 16'h0, 4'b1000, 7'h3F, 0);
        tbl[15] = mk(0, 16'h0, 4'b0000, 7'h66, 1);
        tbl[16] = mk(0, 16'h0, 4'b0001, 7'h66, 0);
        tbl[17] = mk(0, 16'h0, 4'b0001, 7'h66, 0);
        tbl[18] = mk(0, 16'h0, 4'b0001, 7'h66, 0);
        tbl[19] = mk(0, 16'h0, 4'b0000, 7'h4F, 0);

        decade_rst = 1'b1; load = 1'b0; enable = 1'b0; bcd_in = '0;
        model_reset();
        #1;
        chk("por_seg", 32'(seg), 32'h0);
        chk("por_an", 32'(an), 32'h0);
        chk("por_fd", 32'(frame_done), 32'h0);
        chk("por_err", 32'(bcd_err), 32'h0);
        @(negedge clk);
        decade_rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].en, tbl[i].ld, tbl[i].bcd);
            chk("tbl_an", 32'(an), 32'(tbl[i].an));
            chk("tbl_seg", 32'(seg), 32'(tbl[i].seg));
            chk("tbl_fd", 32'(frame_done), 32'(tbl[i].fd));
        end

        // Enable dropped mid-slot for 10 clocks
        step(1, 0, 16'h0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 16'h0);
            chk("t5_an_off", 32'(an), 32'h0);
        end
        for (int i = 0; i < 8; i++) step(1, 0, 16'h0);

        // Two loads in a frame, the second on the wrap edge
        while (m_ecnt % 16 != 8) step(1, 0, 16'h0);
        step(1, 1, 16'h1111);
        while (m_ecnt % 16 != 15) step(1, 0, 16'h0);
        step(1, 1, 16'h5678);
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 16'h0);
            for (int k = 0; k < 4; k++)
                if (an == 4'(1 << k)) chk("t3_seg", 32'(seg), 32'(t3_exp[k]));
        end

        // Invalid digit sets sticky error
        step(1, 1, 16'h00A0);
        for (int i = 0; i < 40; i++) step(1, 0, 16'h0);
        chk("t4_err_set", 32'(bcd_err), 32'h1);
        step(1, 1, 16'h0000);
        for (int i = 0; i < 40; i++) step(1, 0, 16'h0);
        chk("t4_err_sticky", 32'(bcd_err), 32'h1);

        // Asynchronous reset mid-slot, then leading-zero pattern
        while (m_ecnt % 4 != 1) step(1, 0, 16'h0);
        async_reset();
        chk("t6_err_clr", 32'(bcd_err), 32'h0);
        for (int i = 0; i < 6; i++) step(1, 0, 16'h0);
        step(1, 1, 16'h0042);
        for (int i = 0; i < 40; i++) step(1, 0, 16'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < 4; d++)
                rb[4*d +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                            : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) rb = rb & 16'h00FF;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0, rb);
            if (i == 1500) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
